// File: rtl/egress_scheduler.sv
// ---------------------------------------------------------------------------
// egress_scheduler
//   Round-robin scheduler for one egress port of the packet filter switch.
//   Each ingress lane's destination calculator emits a one-cycle dest pulse.
//   Pulses that target this egress are latched as pending requests. One lane
//   at a time is granted, and its beat stream is muxed onto the egress port
//   with zero latency. The grant is held until tlast is accepted or until a
//   stall timeout expires.
//
// Ports
//   clk, reset             clock, synchronous active-low reset
//   req_valid/dest/drop    per-lane dest pulse (lane i dest at [2i+1:2i])
//   in_tdata/tvalid/tlast  per-lane ingress beat stream
//   in_tready              per-lane ready; only the granted lane can be high
//   out_tdata/tvalid/tlast egress beat stream, out_tready egress ready
//   grant_valid/grant_idx  current owner of the egress
//   overflow               sticky: a request hit a lane that was already pending
//   timeout                one-cycle pulse: a grant was aborted by stall timeout
// ---------------------------------------------------------------------------
module egress_scheduler #(
    parameter int         NUM_INGRESS = 4,
    parameter int         DATA_W      = 16,
    parameter logic [1:0] EGRESS_ID   = 2'd0,
    parameter int         TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INGRESS-1:0]        req_valid,
    input  logic [2*NUM_INGRESS-1:0]      req_dest,
    input  logic [NUM_INGRESS-1:0]        req_drop,
    input  logic [DATA_W*NUM_INGRESS-1:0] in_tdata,
    input  logic [NUM_INGRESS-1:0]        in_tvalid,
    input  logic [NUM_INGRESS-1:0]        in_tlast,
    output logic [NUM_INGRESS-1:0]        in_tready,
    output logic [DATA_W-1:0]             out_tdata,
    output logic                          out_tvalid,
    output logic                          out_tlast,
    input  logic                          out_tready,
    output logic                          grant_valid,
    output logic [$clog2(NUM_INGRESS)-1:0] grant_idx,
    output logic                          overflow,
    output logic                          timeout
);

    localparam int IW = $clog2(NUM_INGRESS);
    // With the timeout disabled the counter is unused, but keep it 1 bit wide.
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [NUM_INGRESS-1:0] pending;
    logic [IW-1:0]          last_ptr;
    logic [SW-1:0]          stall_cnt;

    logic [NUM_INGRESS-1:0] hit;
    logic [NUM_INGRESS-1:0] grant_clear;
    logic [IW-1:0]          pick;
    logic [IW-1:0]          cand;
    logic                   pick_found;
    logic                   overflow_set;
    logic                   accept;
    logic                   stall_abort;

    // Request capture and round-robin pick.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        hit         = '0;
        grant_clear = '0;
        pick        = '0;
        cand        = '0;
        pick_found  = 1'b0;

        for (int i = 0; i < NUM_INGRESS; i++) begin
            hit[i] = req_valid[i] & ~req_drop[i] & (req_dest[2*i +: 2] == EGRESS_ID);
        end

        // Search starts one past the last served lane, so the lane just served
        // has the lowest priority. Wraps modulo NUM_INGRESS (any count legal).
        for (int k = 1; k <= NUM_INGRESS; k++) begin
            cand = IW'((int'(last_ptr) + k) % NUM_INGRESS);
            if (!pick_found && pending[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end

        for (int i = 0; i < NUM_INGRESS; i++) begin
            grant_clear[i] = (state == IDLE) && pick_found && (pick == IW'(i));
        end
    end

    // A lane being granted this cycle may take a new hit without overflowing:
    // the new packet simply queues behind the one being granted.
    assign overflow_set = |(hit & pending & ~grant_clear);

    // Zero-latency data path: only the granted lane is visible while BUSY.
    always_comb begin
        out_tdata  = '0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        in_tready  = '0;
        if (state == BUSY) begin
            for (int i = 0; i < NUM_INGRESS; i++) begin
                if (grant_idx == IW'(i)) begin
                    out_tdata    = in_tdata[DATA_W*i +: DATA_W];
                    out_tvalid   = in_tvalid[i];
                    out_tlast    = in_tlast[i];
                    in_tready[i] = out_tready;
                end
            end
        end
    end

    assign accept      = out_tvalid & out_tready;
    assign stall_abort = (TIMEOUT != 0) && (state == BUSY) && !accept &&
                         (stall_cnt == SW'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_ptr    <= IW'(NUM_INGRESS - 1);
            overflow    <= 1'b0;
            timeout     <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            pending <= (pending & ~grant_clear) | hit;
            timeout <= 1'b0;
            if (overflow_set) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (pick_found) begin
                        state       <= BUSY;
                        grant_valid <= 1'b1;
                        grant_idx   <= pick;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end

                    // Release always passes through IDLE for at least one cycle.
                    if ((accept && out_tlast) || stall_abort) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        last_ptr    <= grant_idx;
                        timeout     <= stall_abort;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_egress_scheduler.sv
// ---------------------------------------------------------------------------
// tb_egress_scheduler
//   Directed bench for egress_scheduler (4 lanes, EGRESS_ID=1, TIMEOUT=4).
//   Per-lane beat sources feed the ingress side. Every packet expected on the
//   egress is pushed to a scoreboard queue when it is queued at its source.
//   A negedge monitor pops and compares each accepted egress beat.
// ---------------------------------------------------------------------------
module tb_egress_scheduler;

    localparam int         NI  = 4;
    localparam int         DW  = 16;
    localparam logic [1:0] EID = 2'd1;

    logic               clk = 1'b0;
    logic               reset;
    logic [NI-1:0]      req_valid;
    logic [2*NI-1:0]    req_dest;
    logic [NI-1:0]      req_drop;
    logic [DW*NI-1:0]   in_tdata;
    logic [NI-1:0]      in_tvalid;
    logic [NI-1:0]      in_tlast;
    logic [NI-1:0]      in_tready;
    logic [DW-1:0]      out_tdata;
    logic               out_tvalid;
    logic               out_tlast;
    logic               out_tready;
    logic               grant_valid;
    logic [1:0]         grant_idx;
    logic               overflow;
    logic               timeout;

    egress_scheduler #(
        .NUM_INGRESS (NI),
        .DATA_W      (DW),
        .EGRESS_ID   (EID),
        .TIMEOUT     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_drop    (req_drop),
        .in_tdata    (in_tdata),
        .in_tvalid   (in_tvalid),
        .in_tlast    (in_tlast),
        .in_tready   (in_tready),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tlast   (out_tlast),
        .out_tready  (out_tready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int            lane;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    beat_t src_q [NI][$];
    exp_t  exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int grants_seen = 0;
    int timeouts_seen = 0;
    int exp_grants = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NI-1:0] mask, input logic [2*NI-1:0] dest,
                         input logic [NI-1:0] drop);
        req_valid = mask;
        req_dest  = dest;
        req_drop  = drop;
        step();
        req_valid = '0;
        req_dest  = '0;
        req_drop  = '0;
    endtask

    // Queue a packet at a lane's source and record its beats as expected egress.
    task automatic add_pkt(input int lane, input int n, input logic [DW-1:0] base);
        beat_t bt;
        exp_t  e;
        for (int b = 0; b < n; b++) begin
            bt.data = base + DW'(b);
            bt.last = (b == n - 1);
            src_q[lane].push_back(bt);
            e.lane = lane;
            e.data = bt.data;
            e.last = bt.last;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || grant_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, {31'd0, (exp_q.size() == 0) && !grant_valid}, 32'd1);
        step();
    endtask

    // Ingress beat sources: present the head beat, pop it when accepted.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (in_tvalid[i] && in_tready[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            if (src_q[i].size() > 0) begin
                in_tvalid[i]         = 1'b1;
                in_tdata[DW*i +: DW] = src_q[i][0].data;
                in_tlast[i]          = src_q[i][0].last;
            end else begin
                in_tvalid[i]         = 1'b0;
                in_tdata[DW*i +: DW] = '0;
                in_tlast[i]          = 1'b0;
            end
        end
    end

    // Egress monitor: scoreboard compare, idle-gap check, grant/timeout counts.
    logic prev_gv  = 1'b0;
    logic gap_chk  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (gap_chk) begin
                check("idle_gap_after_tlast", {31'd0, grant_valid}, 32'd0);
                gap_chk = 1'b0;
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {16'd0, out_tdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", {16'd0, out_tdata}, {16'd0, e.data});
                    check("sb_last", {31'd0, out_tlast}, {31'd0, e.last});
                    check("sb_lane", {30'd0, grant_idx}, 32'(e.lane));
                    if (out_tlast) gap_chk = 1'b1;
                end
            end
            if (grant_valid && !prev_gv) grants_seen++;
            if (timeout) timeouts_seen++;
            prev_gv = grant_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        req_dest   = '0;
        req_drop   = '0;
        out_tready = 1'b0;
        repeat (3) step();

        // Reset state.
        @(negedge clk);
        check("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
        check("rst_grant_idx",   {30'd0, grant_idx},   32'd0);
        check("rst_out_tvalid",  {31'd0, out_tvalid},  32'd0);
        check("rst_in_tready",   {28'd0, in_tready},   32'd0);
        check("rst_overflow",    {31'd0, overflow},    32'd0);
        check("rst_timeout",     {31'd0, timeout},     32'd0);
        step();
        reset = 1'b1;
        step();

        // 1: single 3-beat packet on lane 2, grant two cycles after the hit.
        out_tready = 1'b1;
        add_pkt(2, 3, 16'h2100);
        exp_grants++;
        pulse(4'b0100, 8'h55, 4'b0000);
        @(negedge clk);
        check("t1_no_grant_yet", {31'd0, grant_valid}, 32'd0);
        step();
        @(negedge clk);
        check("t1_grant_valid", {31'd0, grant_valid}, 32'd1);
        check("t1_grant_idx",   {30'd0, grant_idx},   32'd2);
        check("t1_first_data",  {16'd0, out_tdata},   32'h2100);
        check("t1_tready_only_granted", {28'd0, in_tready}, 32'h4);
        wait_drain("t1", 20);

        // 2: three lanes at once from fresh pointer -> 0,1,3.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        add_pkt(0, 1, 16'h0100);
        add_pkt(1, 1, 16'h1100);
        add_pkt(3, 1, 16'h3100);
        exp_grants += 3;
        pulse(4'b1011, 8'h55, 4'b0000);
        wait_drain("t2", 40);
        // Serve lane 2 so the pointer sits at 2; then lanes 0,3 -> 3 then 0.
        add_pkt(2, 1, 16'h2200);
        exp_grants++;
        pulse(4'b0100, 8'h55, 4'b0000);
        wait_drain("t2b", 20);
        add_pkt(3, 1, 16'h3200);
        add_pkt(0, 1, 16'h0200);
        exp_grants += 2;
        pulse(4'b1001, 8'h55, 4'b0000);
        wait_drain("t2c", 20);

        // 3: dropped request and request for another egress are ignored.
        pulse(4'b0001, 8'h55, 4'b0001);
        pulse(4'b0010, 8'h08, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_no_grant", {31'd0, grant_valid}, 32'd0);
        end
        step();

        // 4: lane 1 hit twice while lane 0 is busy -> overflow, one grant.
        add_pkt(0, 3, 16'h0300);
        add_pkt(1, 1, 16'h1300);
        exp_grants += 2;
        pulse(4'b0001, 8'h55, 4'b0000);
        step();
        pulse(4'b0010, 8'h55, 4'b0000);
        @(negedge clk);
        check("t4_no_overflow_yet", {31'd0, overflow}, 32'd0);
        pulse(4'b0010, 8'h55, 4'b0000);
        @(negedge clk);
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        wait_drain("t4", 30);
        check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 5: lane 2 granted with no data -> timeout after 4 BUSY cycles; lane 3 next.
        add_pkt(3, 1, 16'h3400);
        exp_grants += 2;
        pulse(4'b1100, 8'h55, 4'b0000);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_busy_gv",  {31'd0, grant_valid}, 32'd1);
            check("t5_busy_idx", {30'd0, grant_idx},   32'd2);
            check("t5_busy_to",  {31'd0, timeout},     32'd0);
        end
        @(negedge clk);
        check("t5_timeout_pulse", {31'd0, timeout},     32'd1);
        check("t5_released",      {31'd0, grant_valid}, 32'd0);
        @(negedge clk);
        check("t5_timeout_gone",  {31'd0, timeout},     32'd0);
        check("t5_next_gv",       {31'd0, grant_valid}, 32'd1);
        check("t5_next_idx",      {30'd0, grant_idx},   32'd3);
        wait_drain("t5", 20);

        // 6: move pointer to lane 1, then reset mid-packet with tready toggling.
        add_pkt(1, 1, 16'h1500);
        exp_grants++;
        pulse(4'b0010, 8'h55, 4'b0000);
        wait_drain("t6a", 20);
        add_pkt(2, 4, 16'h2500);
        exp_grants++;
        pulse(4'b0100, 8'h55, 4'b0000);
        step();
        out_tready = 1'b0;
        step();
        out_tready = 1'b1;
        step();
        out_tready = 1'b0;
        step();
        out_tready = 1'b1;
        reset      = 1'b0;
        step();
        @(negedge clk);
        check("t6_rst_gv",       {31'd0, grant_valid}, 32'd0);
        check("t6_rst_idx",      {30'd0, grant_idx},   32'd0);
        check("t6_rst_tvalid",   {31'd0, out_tvalid},  32'd0);
        check("t6_rst_tdata",    {16'd0, out_tdata},   32'd0);
        check("t6_rst_tready",   {28'd0, in_tready},   32'd0);
        check("t6_rst_overflow", {31'd0, overflow},    32'd0);
        exp_q.delete();
        for (int i = 0; i < NI; i++) src_q[i].delete();
        step();
        reset = 1'b1;
        step();
        add_pkt(0, 1, 16'h0600);
        add_pkt(3, 1, 16'h3600);
        exp_grants += 2;
        pulse(4'b1001, 8'h55, 4'b0000);
        step();
        @(negedge clk);
        check("t6_tie_gv",  {31'd0, grant_valid}, 32'd1);
        check("t6_tie_idx", {30'd0, grant_idx},   32'd0);
        wait_drain("t6", 20);

        repeat (3) step();
        check("grant_count",   32'(grants_seen),   32'(exp_grants));
        check("timeout_count", 32'(timeouts_seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
